// File: rtl/fighter_controller.sv
// Per-player movement, jump, three-phase attack and hitstun controller.
// All state advances once per SCEN frame tick; outputs feed the hit resolver.
module fighter_controller #(
    parameter int POS_WIDTH        = 10,
    parameter int X_MIN            = 16,
    parameter int X_MAX            = 624,
    parameter int GROUND_Y         = 400,
    parameter int START_X          = 160,
    parameter bit START_FACE_RIGHT = 1'b1,
    parameter int WALK_SPEED       = 2,
    parameter int JUMP_VY          = -10,
    parameter int GRAVITY          = 1,
    parameter int VY_MAX           = 15,
    parameter int ATK_STARTUP      = 3,
    parameter int ATK_ACTIVE       = 4,
    parameter int ATK_RECOVERY     = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 SCEN,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic                 btn_jump,
    input  logic                 btn_attack,
    input  logic                 hit_event,
    input  logic                 hitstun_active,
    input  logic signed [7:0]    kb_dx,
    input  logic signed [7:0]    kb_dy,
    output logic [POS_WIDTH-1:0] pos_x,
    output logic [POS_WIDTH-1:0] pos_y,
    output logic                 face_right,
    output logic                 attack_active,
    output logic [2:0]           state,
    output logic                 on_ground
);
    localparam int XW = POS_WIDTH + 2;
    localparam logic signed [XW-1:0] XMIN_S = XW'(X_MIN);
    localparam logic signed [XW-1:0] XMAX_S = XW'(X_MAX);
    localparam logic signed [XW-1:0] YG     = XW'(GROUND_Y);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WALK        = 3'd1,
        ST_JUMP        = 3'd2,
        ST_ATK_STARTUP = 3'd3,
        ST_ATK_ACTIVE  = 3'd4,
        ST_ATK_RECOVER = 3'd5,
        ST_HITSTUN     = 3'd6
    } state_t;

    state_t                 st, st_n;
    logic signed [XW-1:0]   x, y, x_sum, x_c, y_sum, y_v, y_n;
    logic signed [7:0]      vx, vy, vx_n, vy_v, vy_n, move, dx;
    logic signed [8:0]      vy_sum;
    logic [7:0]             cnt, cnt_n;
    logic                   atk_prev, atk_edge, face_n;

    always_comb begin
        move = '0;
        if (btn_left && !btn_right)
            move = 8'(-WALK_SPEED);
        else if (btn_right && !btn_left)
            move = 8'(WALK_SPEED);
    end

    assign atk_edge = btn_attack && !atk_prev;

    // Horizontal displacement: knockback in stun, none while attacking or on the attack-start tick.
    always_comb begin
        dx = '0;
        if (!hit_event) begin
            if (st == ST_HITSTUN)
                dx = vx;
            else if (st == ST_JUMP)
                dx = move;
            else if ((st == ST_IDLE || st == ST_WALK) && (btn_jump || !atk_edge))
                dx = move;
        end
    end

    always_comb begin
        x_sum = x + XW'(dx);
        if (x_sum < XMIN_S)
            x_c = XMIN_S;
        else if (x_sum > XMAX_S)
            x_c = XMAX_S;
        else
            x_c = x_sum;
    end

    // Gravity runs whenever above the floor or still carrying vertical speed.
    always_comb begin
        y_v    = y;
        vy_v   = vy;
        y_sum  = y;
        vy_sum = 9'(vy);
        if (y < YG || vy != 8'sd0) begin
            y_sum  = y + XW'(vy);
            vy_sum = 9'(vy) + 9'(GRAVITY);
            vy_v   = (vy_sum > 9'(VY_MAX)) ? 8'(VY_MAX) : vy_sum[7:0];
            if (y_sum >= YG) begin
                y_v  = YG;
                vy_v = '0;
            end else begin
                y_v = y_sum;
            end
        end
    end

    always_comb begin
        st_n   = st;
        y_n    = y_v;
        vx_n   = vx;
        vy_n   = vy_v;
        cnt_n  = cnt;
        face_n = face_right;
        if (hit_event) begin
            st_n  = ST_HITSTUN;
            y_n   = y;
            vx_n  = kb_dx;
            vy_n  = kb_dy;
            cnt_n = '0;
        end else begin
            if ((st == ST_IDLE || st == ST_WALK || st == ST_JUMP) && move != 8'sd0)
                face_n = btn_right;
            case (st)
                ST_IDLE, ST_WALK: begin
                    if (btn_jump) begin
                        st_n = ST_JUMP;
                        vy_n = 8'(JUMP_VY);
                    end else if (atk_edge) begin
                        st_n  = ST_ATK_STARTUP;
                        cnt_n = '0;
                    end else begin
                        st_n = (move != 8'sd0) ? ST_WALK : ST_IDLE;
                    end
                end
                ST_JUMP: begin
                    if (y_v == YG)
                        st_n = ST_IDLE;
                end
                ST_ATK_STARTUP: begin
                    if (cnt == 8'(ATK_STARTUP - 1)) begin
                        st_n  = ST_ATK_ACTIVE;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                ST_ATK_ACTIVE: begin
                    if (cnt == 8'(ATK_ACTIVE - 1)) begin
                        st_n  = ST_ATK_RECOVER;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                ST_ATK_RECOVER: begin
                    if (cnt == 8'(ATK_RECOVERY - 1)) begin
                        st_n  = ST_IDLE;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                ST_HITSTUN: begin
                    if (!hitstun_active) begin
                        vx_n = '0;
                        st_n = (y_v == YG) ? ST_IDLE : ST_JUMP;
                    end
                end
                default: st_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st            <= ST_IDLE;
            x             <= XW'(START_X);
            y             <= YG;
            vx            <= '0;
            vy            <= '0;
            cnt           <= '0;
            atk_prev      <= 1'b0;
            face_right    <= START_FACE_RIGHT;
            attack_active <= 1'b0;
            pos_x         <= POS_WIDTH'(START_X);
            pos_y         <= POS_WIDTH'(GROUND_Y);
            on_ground     <= 1'b1;
        end else if (SCEN) begin
            st            <= st_n;
            x             <= x_c;
            y             <= y_n;
            vx            <= vx_n;
            vy            <= vy_n;
            cnt           <= cnt_n;
            atk_prev      <= btn_attack;
            face_right    <= face_n;
            attack_active <= (st_n == ST_ATK_ACTIVE);
            pos_x         <= x_c[POS_WIDTH-1:0];
            pos_y         <= y_n[POS_WIDTH-1:0];
            on_ground     <= (y_n == YG);
        end
    end

    assign state = st;

endmodule

// File: tb/tb_fighter_controller.sv
// Scoreboard bench for fighter_controller: directed ticks push expected outputs,
// a monitor pops and compares one entry after every clock edge.
module tb_fighter_controller;
    logic              clk = 1'b0;
    logic              reset, SCEN;
    logic              btn_left, btn_right, btn_jump, btn_attack;
    logic              hit_event, hitstun_active;
    logic signed [7:0] kb_dx, kb_dy;
    logic [9:0]        pos_x, pos_y;
    logic              face_right, attack_active, on_ground;
    logic [2:0]        state;

    localparam int MX = 1, MY = 2, MF = 4, MA = 8, MS = 16, MG = 32, ALL = 63;
    localparam int IDLE = 0, WALK = 1, JUMP = 2, STARTUP = 3, ACTIVE = 4, RECOVER = 5, HITSTUN = 6;

    typedef struct {
        int mask;
        int x;
        int y;
        int f;
        int a;
        int st;
        int g;
    } exp_t;

    exp_t  sb[$];
    string nq[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    hy[8] = '{398, 397, 397, 398, 400, 400, 400, 400};

    fighter_controller dut (
        .clk(clk), .reset(reset), .SCEN(SCEN),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump), .btn_attack(btn_attack),
        .hit_event(hit_event), .hitstun_active(hitstun_active), .kb_dx(kb_dx), .kb_dy(kb_dy),
        .pos_x(pos_x), .pos_y(pos_y), .face_right(face_right), .attack_active(attack_active),
        .state(state), .on_ground(on_ground)
    );

    always #5 clk = ~clk;

    // Closed-form jump height k ticks after take-off: 400 - 10k + k(k-1)/2.
    function automatic int jy(input int k);
        return 400 - 10 * k + (k * (k - 1)) / 2;
    endfunction

    task automatic clearInputs();
        btn_left = 0; btn_right = 0; btn_jump = 0; btn_attack = 0;
        hit_event = 0; hitstun_active = 0; kb_dx = '0; kb_dy = '0;
    endtask

    task automatic applyStimulus(input string nm, input int mask, input int x, input int y,
                                 input int f, input int a, input int st, input int g);
        exp_t e;
        e.mask = mask; e.x = x; e.y = y; e.f = f; e.a = a; e.st = st; e.g = g;
        sb.push_back(e);
        nq.push_back(nm);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string nm, input string field, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("[TB] FAIL %s %s: got %0d, expected %0d", nm, field, act, expv);
        end
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                nm = nq.pop_front();
                if ((e.mask & MX) != 0) checkOutput(nm, "pos_x", int'(pos_x), e.x);
                if ((e.mask & MY) != 0) checkOutput(nm, "pos_y", int'(pos_y), e.y);
                if ((e.mask & MF) != 0) checkOutput(nm, "face_right", int'(face_right), e.f);
                if ((e.mask & MA) != 0) checkOutput(nm, "attack_active", int'(attack_active), e.a);
                if ((e.mask & MS) != 0) checkOutput(nm, "state", int'(state), e.st);
                if ((e.mask & MG) != 0) checkOutput(nm, "on_ground", int'(on_ground), e.g);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        clearInputs();
        reset = 1; SCEN = 1;
        applyStimulus("reset", ALL, 160, 400, 1, 0, IDLE, 1);
        reset = 0;

        // Walk right 10 ticks, then keep pushing into the right wall.
        btn_right = 1;
        for (int k = 1; k <= 240; k++) begin
            if (k <= 10)
                applyStimulus("walk_right", MX | MS | MF, 160 + 2 * k, 0, 1, 0, WALK, 0);
            else
                applyStimulus("clamp_right", MX | MS, (160 + 2 * k > 624) ? 624 : 160 + 2 * k, 0, 1, 0, WALK, 0);
        end
        btn_right = 0;
        applyStimulus("release", ALL, 624, 400, 1, 0, IDLE, 1);

        btn_left = 1;
        for (int k = 1; k <= 5; k++)
            applyStimulus("walk_left", MX | MF | MS, 624 - 2 * k, 0, 0, 0, WALK, 0);
        btn_left = 0;
        applyStimulus("release_left", MX | MS, 614, 0, 0, 0, IDLE, 0);

        btn_left = 1; btn_right = 1;
        for (int k = 1; k <= 3; k++)
            applyStimulus("both_held", MX | MF | MS, 614, 0, 0, 0, IDLE, 0);
        btn_left = 0; btn_right = 0;

        // Jump with left drift through the air until landing.
        btn_jump = 1;
        applyStimulus("jump_takeoff", ALL, 614, 400, 0, 0, JUMP, 1);
        btn_jump = 0; btn_left = 1;
        for (int k = 1; k <= 21; k++)
            applyStimulus("jump_arc", ALL, 614 - 2 * k, jy(k), 0, 0, (k == 21) ? IDLE : JUMP, (k == 21) ? 1 : 0);
        btn_left = 0;

        // Attack with button held, right held during the phases: no move, no retrigger.
        btn_attack = 1;
        applyStimulus("atk_start", ALL, 572, 400, 0, 0, STARTUP, 1);
        for (int k = 1; k <= 16; k++) begin
            btn_right = (k <= 12);
            applyStimulus("atk_phase", MX | MF | MA | MS, 572, 0, 0, (k >= 3 && k <= 6) ? 1 : 0,
                          (k < 3) ? STARTUP : (k <= 6) ? ACTIVE : (k <= 12) ? RECOVER : IDLE, 0);
        end
        btn_right = 0; btn_attack = 0;
        applyStimulus("atk_release", MS | MA, 0, 0, 0, 0, IDLE, 0);

        // Hit during the active phase.
        btn_attack = 1;
        applyStimulus("atk2_start", MS, 0, 0, 0, 0, STARTUP, 0);
        btn_attack = 0;
        for (int k = 1; k <= 4; k++)
            applyStimulus("atk2_phase", MS | MA, 0, 0, 0, (k >= 3) ? 1 : 0, (k >= 3) ? ACTIVE : STARTUP, 0);
        hit_event = 1; hitstun_active = 1; kb_dx = -8'sd4; kb_dy = -8'sd2;
        applyStimulus("hit", ALL, 572, 400, 0, 0, HITSTUN, 1);
        hit_event = 0; kb_dx = '0; kb_dy = '0;
        for (int m = 1; m <= 8; m++)
            applyStimulus("knockback", MX | MY | MA | MS | MG, 572 - 4 * m, hy[m-1], 0, 0, HITSTUN, (hy[m-1] == 400) ? 1 : 0);
        hitstun_active = 0;
        applyStimulus("stun_exit", ALL, 536, 400, 0, 0, IDLE, 1);
        applyStimulus("stun_after", MX | MS, 536, 0, 0, 0, IDLE, 0);

        // Large knockback toward the left wall goes negative and clamps.
        hit_event = 1; hitstun_active = 1; kb_dx = -8'sd100; kb_dy = '0;
        applyStimulus("hit2", MX | MS, 536, 0, 0, 0, HITSTUN, 0);
        hit_event = 0; kb_dx = '0;
        for (int m = 1; m <= 6; m++)
            applyStimulus("clamp_left", MX | MY | MS, (536 - 100 * m < 16) ? 16 : 536 - 100 * m, 400, 0, 0, HITSTUN, 0);
        hitstun_active = 0;
        applyStimulus("stun2_exit", MX | MS, 16, 0, 0, 0, IDLE, 0);

        // Jump and attack edge together: jump wins; attack edges in the air are ignored.
        btn_jump = 1; btn_attack = 1;
        applyStimulus("jump_vs_atk", ALL, 16, 400, 0, 0, JUMP, 1);
        btn_jump = 0;
        for (int k = 1; k <= 21; k++) begin
            btn_attack = (k == 1 || k == 3);
            applyStimulus("air_atk", MY | MA | MS, 0, jy(k), 0, 0, (k == 21) ? IDLE : JUMP, 0);
        end
        btn_attack = 0;

        // Freeze mid-air with SCEN low, then reset while frozen.
        btn_jump = 1;
        applyStimulus("jump3", MS, 0, 0, 0, 0, JUMP, 0);
        btn_jump = 0;
        for (int k = 1; k <= 4; k++)
            applyStimulus("jump3_arc", MY, 0, jy(k), 0, 0, 0, 0);
        SCEN = 0; btn_right = 1; btn_attack = 1; btn_jump = 1;
        for (int k = 1; k <= 5; k++)
            applyStimulus("scen_low", ALL, 16, 366, 0, 0, JUMP, 0);
        clearInputs();
        reset = 1;
        applyStimulus("reset_scen_low", ALL, 160, 400, 1, 0, IDLE, 1);
        reset = 0; SCEN = 1;
        applyStimulus("post_reset", ALL, 160, 400, 1, 0, IDLE, 1);

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
